// File: rtl/trace_reorder_buffer_pkg.sv
// Shared types for the trace reorder buffer: event kinds, the event descriptor
// and the timestamp width used when TRACE_TIMESTAMP_EN is defined.
package trace_reorder_buffer_pkg;

    localparam int TS_W = 32;

    typedef enum logic [1:0] {
        INVALID,
        SWRITEBACK,
        VWRITEBACK,
        STORE
    } trace_event_type_t;

    typedef struct packed {
        trace_event_type_t etype;
        logic [TS_W-1:0]   timestamp;
    } trace_event_t;

endpackage

// File: rtl/trace_reorder_buffer_output_fifo.sv
// Show-ahead output FIFO for the trace reorder buffer; a push is accepted on a
// full FIFO when a pop happens on the same edge.
module trace_output_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so equal indices can mean full or empty.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/trace_reorder_buffer.sv
// Trace reorder buffer: sources insert at fixed slots of a shifting line that
// drains into an output FIFO. Define TRACE_TIMESTAMP_EN to add out_timestamp.
module trace_reorder_buffer
    import trace_reorder_buffer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NUM_SOURCES = 4,
    parameter int EVENT_WIDTH = 512,
    // Source i occupies bits [i*$clog2(DEPTH) +: $clog2(DEPTH)]; default is src0..3 -> 0,3,4,5.
    parameter logic [NUM_SOURCES*$clog2(DEPTH)-1:0] SLOT_MAP = {3'd5, 3'd4, 3'd3, 3'd0},
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_SOURCES-1:0]             insert_en,
    input  logic [NUM_SOURCES*EVENT_WIDTH-1:0] insert_data,
    input  logic [DEPTH-1:0]                   kill_en,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [EVENT_WIDTH-1:0]             out_event,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]                    out_timestamp,
`endif
    output logic                               overflow,
    output logic                               collision,
    output logic [31:0]                        dropped_count
);

    localparam int SW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int FW = EVENT_WIDTH + TS_W;
`else
    localparam int FW = EVENT_WIDTH;
`endif

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [EVENT_WIDTH-1:0] data_q [DEPTH];
    logic [EVENT_WIDTH-1:0] data_d [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]        ts_q [DEPTH];
    logic [TS_W-1:0]        ts_d [DEPTH];
    logic [TS_W-1:0]        cycle_q, cycle_d;
`endif
    logic                   overflow_q, overflow_d;
    logic                   collision_q, collision_d;
    logic [31:0]            dropped_q, dropped_d;

    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop, head_drop;
    logic [FW-1:0]          fifo_push_data, fifo_head;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        // Drain: the pop of this edge frees room before the head is judged.
        fifo_pop  = !fifo_empty && out_ready;
        fifo_push = valid_q[0] && (!fifo_full || fifo_pop);
        head_drop = valid_q[0] && fifo_full && !fifo_pop;
`ifdef TRACE_TIMESTAMP_EN
        fifo_push_data = {ts_q[0], data_q[0]};
        cycle_d        = cycle_q + 32'd1;
        for (int i = 0; i < DEPTH - 1; i++) ts_d[i] = ts_q[i+1];
        ts_d[DEPTH-1]  = '0;
`else
        fifo_push_data = data_q[0];
`endif

        for (int i = 0; i < DEPTH - 1; i++) begin
            valid_d[i] = valid_q[i+1];
            data_d[i]  = data_q[i+1];
        end
        valid_d[DEPTH-1] = 1'b0;
        data_d[DEPTH-1]  = '0;

        // Lower-index sources are visited first, so they win shared slots.
        collision_d = collision_q;
        for (int s = 0; s < NUM_SOURCES; s++) begin
            if (insert_en[s]) begin
                if (valid_d[SLOT_MAP[s*SW +: SW]]) begin
                    collision_d = 1'b1;
                end else begin
                    valid_d[SLOT_MAP[s*SW +: SW]] = 1'b1;
                    data_d[SLOT_MAP[s*SW +: SW]]  = insert_data[s*EVENT_WIDTH +: EVENT_WIDTH];
`ifdef TRACE_TIMESTAMP_EN
                    ts_d[SLOT_MAP[s*SW +: SW]]    = cycle_q;
`endif
                end
            end
        end

        for (int j = 0; j < DEPTH; j++) begin
            if (kill_en[j]) valid_d[j] = 1'b0;
        end

        overflow_d = overflow_q | head_drop;
        dropped_d  = head_drop ? sat_inc(dropped_q) : dropped_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
            dropped_q   <= '0;
`ifdef TRACE_TIMESTAMP_EN
            cycle_q     <= '0;
`endif
        end else begin
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            collision_q <= collision_d;
            dropped_q   <= dropped_d;
`ifdef TRACE_TIMESTAMP_EN
            cycle_q     <= cycle_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
`ifdef TRACE_TIMESTAMP_EN
        ts_q   <= ts_d;
`endif
    end

    trace_output_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_data(fifo_head)
    );

    assign out_valid     = !fifo_empty;
    assign out_event     = fifo_head[EVENT_WIDTH-1:0];
`ifdef TRACE_TIMESTAMP_EN
    assign out_timestamp = fifo_head[FW-1 -: TS_W];
`endif
    assign overflow      = overflow_q;
    assign collision     = collision_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_trace_reorder_buffer.sv
// Directed bench for trace_reorder_buffer with an expected-event scoreboard
// (DEPTH=8, three sources at slots 4, 3, 0, FIFO_DEPTH=4).
module tb_trace_reorder_buffer;

    localparam int EW = 64;
    localparam int NS = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS-1:0]     insert_en;
    logic [NS*EW-1:0]  insert_data;
    logic [7:0]        kill_en;
    logic              out_valid;
    logic              out_ready;
    logic [EW-1:0]     out_event;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       out_timestamp;
    int unsigned       edge_cnt;
`endif
    logic              overflow;
    logic              collision;
    logic [31:0]       dropped_count;

    typedef struct {
        logic [EW-1:0] data;
        logic [31:0]   ts;
    } exp_t;
    exp_t exp_q[$];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    trace_reorder_buffer #(
        .DEPTH      (8),
        .NUM_SOURCES(NS),
        .EVENT_WIDTH(EW),
        .SLOT_MAP   ({3'd0, 3'd3, 3'd4}),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .insert_en    (insert_en),
        .insert_data  (insert_data),
        .kill_en      (kill_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_event    (out_event),
`ifdef TRACE_TIMESTAMP_EN
        .out_timestamp(out_timestamp),
`endif
        .overflow     (overflow),
        .collision    (collision),
        .dropped_count(dropped_count)
    );

`ifdef TRACE_TIMESTAMP_EN
    always @(posedge clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int s, input logic [EW-1:0] v);
        insert_en[s]           = 1'b1;
        insert_data[s*EW +: EW] = v;
    endtask

    task automatic expect_evt(input logic [EW-1:0] v);
        exp_t e;
        e.data = v;
`ifdef TRACE_TIMESTAMP_EN
        e.ts   = edge_cnt;
`else
        e.ts   = '0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic drain_wait(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every transfer seen half a cycle before its edge is matched.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_event", out_event, e.data);
`ifdef TRACE_TIMESTAMP_EN
                check("sb_ts", out_timestamp, e.ts);
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; insert_en = '0; insert_data = '0; kill_en = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_event", out_event, 0);
        check("rst_overflow", overflow, 0);
        check("rst_collision", collision, 0);
        check("rst_dropped", dropped_count, 0);
        reset = 1'b0;
        tick();

        // Ordering: A@slot4 edge0, B@slot3 edge2, C@slot0 edge6
        put(0, 64'hA0A0_0000_0000_0001); expect_evt(64'hA0A0_0000_0000_0001);
        tick();
        insert_en = '0; tick();
        put(1, 64'hB0B0_0000_0000_0002); expect_evt(64'hB0B0_0000_0000_0002);
        tick();
        insert_en = '0; tick(); tick();
        check("ord_edge4_valid", out_valid, 0);
        tick();
        check("ord_edge5_valid", out_valid, 1);
        check("ord_edge5_A", out_event, 64'hA0A0_0000_0000_0001);
        put(2, 64'hC0C0_0000_0000_0003); expect_evt(64'hC0C0_0000_0000_0003);
        tick();
        check("ord_edge6_B", out_event, 64'hB0B0_0000_0000_0002);
        insert_en = '0; tick();
        check("ord_edge7_C", out_event, 64'hC0C0_0000_0000_0003);
        tick();
        check("ord_edge8_empty", out_valid, 0);
        check("ord_no_collision", collision, 0);

        // Collision: src1 at slot 3 meets src0's entry shifted into slot 3
        put(0, 64'hD0D0_0000_0000_0004); expect_evt(64'hD0D0_0000_0000_0004);
        tick();
        insert_en = '0;
        put(1, 64'hE0E0_0000_0000_0005);
        tick();
        insert_en = '0;
        check("coll_flag", collision, 1);
        drain_wait("coll_drain");
        for (int i = 0; i < 8; i++) tick();
        check("coll_only_src0", out_valid, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("coll_cleared", collision, 0);

        // Kill on the insert edge
        put(0, 64'hF0F0_0000_0000_0006); kill_en = 8'h10;
        tick();
        insert_en = '0; kill_en = '0;
        for (int i = 0; i < 8; i++) tick();
        check("kill_no_out", out_valid, 0);
        check("kill_overflow", overflow, 0);
        check("kill_collision", collision, 0);

        // Backpressure: six events into a 4-entry FIFO
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            insert_en = '0;
            put(2, 64'h6000_0000_0000_0000 + 64'(k));
            if (k < 4) expect_evt(64'h6000_0000_0000_0000 + 64'(k));
            tick();
        end
        insert_en = '0;
        tick();
        check("bp_overflow", overflow, 1);
        check("bp_dropped", dropped_count, 2);
        check("bp_valid", out_valid, 1);
        check("bp_head", out_event, 64'h6000_0000_0000_0000);
        // Simultaneous push and pop on a full FIFO
        put(2, 64'h7777_0000_0000_0007); expect_evt(64'h7777_0000_0000_0007);
        tick();
        insert_en = '0;
        check("bp_head_stable", out_event, 64'h6000_0000_0000_0000);
        out_ready = 1'b1;
        tick();
        check("full_pushpop_nodrop", dropped_count, 2);
        drain_wait("bp_drain");
        tick();
        check("bp_empty", out_valid, 0);

        // Reset with three events in flight
        for (int k = 0; k < 3; k++) begin
            insert_en = '0;
            put(0, 64'h9000_0000_0000_0000 + 64'(k));
            tick();
        end
        insert_en = '0;
        reset = 1'b1;
        tick();
        check("rstmid_valid", out_valid, 0);
        check("rstmid_dropped", dropped_count, 0);
        check("rstmid_overflow", overflow, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rstmid_no_out", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
